i2s_bram_capture: RTL and testbench
===================================

# i2s_bram_capture

Capture-side counterpart to the BRAM sample player: accepts a stream of signed 16-bit audio samples through a valid/ready handshake, buffers them in a small FIFO, and writes them as 32-bit words into the shared BRAM port, one sample per word, at byte address `BASE_ADDR + 4*index`. It supports one-shot and circular recording, is armed and stopped by the PS-side control logic, and uses the same word layout the player reads: sample in bits [15:0], sign-extended into [31:16].

## Interface
- `NUM_WORDS`, 256: capture length in words (≥2).
- `FIFO_DEPTH`, 4: input FIFO entries (power of two, ≥2).
- `BASE_ADDR`, 0: byte address of word 0 (multiple of 4).

- `clk`  input  1  system clock; also drives `BRAM_clk`.
- `rst`  input  1  reset, asynchronous, active-low.
- `BRAM_addr`  output  32  BRAM byte address.
- `BRAM_clk`  output  1  equals `clk`.
- `BRAM_din`  output  32  write data.
- `BRAM_dout`  input  32  unused; present for port compatibility.
- `BRAM_en`  output  1  BRAM enable.
- `BRAM_rst`  output  1  BRAM reset.
- `BRAM_we`  output  4  byte write enables.
- `bram_grant`  input  1  when low, no BRAM write is issued this cycle.
- `arm`  input  1  start a capture (pulse).
- `stop`  input  1  end capture early (pulse).
- `circular`  input  1  sampled on `arm`; 1 means wrap at `NUM_WORDS`.
- `sample_in`  input  16  signed sample.
- `sample_valid`  input  1  `sample_in` is valid.
- `sample_ready`  output  1  block accepts the sample this cycle.
- `done`  output  1  capture finished; held high.
- `wrapped`  output  1  sticky: at least one wrap occurred.
- `overflow`  output  1  sticky: a sample was offered while not ready in CAPTURE.
- `words_written`  output  $clog2(NUM_WORDS)+1  count of words written since arm, saturating at `NUM_WORDS`.

## Operation
- States:
  - IDLE: reset state. `BRAM_en` is 0. On `arm`, go to CAPTURE.
  - CAPTURE: accept samples and write them.
  - DRAIN: no new samples are accepted; flush the FIFO, then go to DONE.
  - DONE: `done` is 1. On `arm`, go to CAPTURE.
- On `arm` (IDLE or DONE):
  - `index`, `words_written`, `overflow`, `wrapped` and `done` are cleared; the FIFO is flushed.
  - `circular` is latched.
  - `arm` is ignored in CAPTURE and DRAIN.
- `sample_ready` is combinational: `state==CAPTURE && !fifo_full`.
  - A push happens when `sample_valid && sample_ready`.
  - A push is never accepted while the FIFO is full, even if a pop occurs in the same cycle.
- Write issue happens when the FIFO is not empty, `bram_grant==1`, and state is CAPTURE or DRAIN. In the next cycle:
  - `BRAM_en`=1, `BRAM_we`=4'hF
  - `BRAM_addr`=`BASE_ADDR+{index,2'b00}`
  - `BRAM_din`={{16{s[15]}},s}
  - pop the FIFO and increment `index`
  - Otherwise `BRAM_en`=0 and `BRAM_we`=0; `BRAM_addr` and `BRAM_din` hold their values.
- After writing index `NUM_WORDS-1`:
  - One-shot: go to DONE; remaining FIFO contents are discarded.
  - Circular: `index` wraps to 0, `wrapped` is set to 1, and the state stays in CAPTURE (or DRAIN).
- `stop` in CAPTURE goes to DRAIN. DRAIN goes to DONE once the FIFO is empty and no write is pending.
- If `stop` arrives in the same cycle as the final one-shot write, the block goes to DONE (not DRAIN).
- `overflow` is set when `sample_valid && !sample_ready` in CAPTURE. It is not set in IDLE, DRAIN or DONE.
- `words_written` increments with each write and saturates at `NUM_WORDS` in circular mode.

## Timing
- Reset values (while `rst`=0):
  - `BRAM_addr`=0, `BRAM_din`=0, `BRAM_en`=0, `BRAM_we`=0, `BRAM_rst`=1
  - `done`=0, `wrapped`=0, `overflow`=0, `words_written`=0
  - state IDLE, FIFO empty
- `BRAM_rst` deasserts on the first `clk` edge after reset release.
- All outputs except `sample_ready` and `BRAM_clk` are registered.
- Latency:
  - `arm` at edge N gives `sample_ready`=1 after edge N.
  - A sample pushed at edge M into an empty FIFO, with grant high, is driven on BRAM after edge M+1.
  - Sustained throughput is 1 sample/cycle.
- `done` rises on the edge after the last write is issued.
- Reset mid-capture: immediate return to reset values; FIFO contents are lost.

## Test plan
- One-shot, `NUM_WORDS`=8: arm, stream samples 0x0001..0x0008 back-to-back, grant held high. Expect:
  - 8 writes at addresses 0x00..0x1C with `BRAM_we`=F
  - `done`=1 one cycle after the last write
  - `words_written`=8, `overflow`=0
- Sign extension: sample 0x8000 is written as 0xFFFF8000; sample 0x7FFF is written as 0x00007FFF.
- Backpressure, `FIFO_DEPTH`=4, grant held low: after 4 accepted samples `sample_ready`=0. A 5th `sample_valid` sets `overflow`=1. After grant goes high, 4 writes follow in order.
- Circular, `NUM_WORDS`=4: push 6 samples. Expect:
  - addresses 0,4,8,C,0,4
  - `wrapped`=1, `words_written`=4
  - `done`=0 until `stop`, then `done`=1 after the FIFO drains
- `stop` with 3 samples queued (grant low): `sample_ready` drops immediately. Grant high then gives exactly 3 writes, then `done`=1. A new `arm` clears all flags.
- Async reset asserted mid-write: outputs take reset values without waiting for a clock edge. A re-arm starts writing at `BASE_ADDR`.

Source files
------------

// File: rtl/i2s_bram_capture.sv
// i2s_bram_capture: accepts signed 16-bit samples over valid/ready, queues them in a
// small FIFO and writes each one, sign-extended to 32 bits, into a shared BRAM port.
module i2s_bram_capture #(
  parameter int          NUM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [31:0]               BRAM_addr,
  output logic                      BRAM_clk,
  output logic [31:0]               BRAM_din,
  input  logic [31:0]               BRAM_dout,
  output logic                      BRAM_en,
  output logic                      BRAM_rst,
  output logic [3:0]                BRAM_we,
  input  logic                      bram_grant,
  input  logic                      arm,
  input  logic                      stop,
  input  logic                      circular,
  input  logic [15:0]               sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      done,
  output logic                      wrapped,
  output logic                      overflow,
  output logic [$clog2(NUM_WORDS):0] words_written
);

  localparam int IW  = $clog2(NUM_WORDS);
  localparam int CW  = IW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [15:0]     mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [FCW-1:0]  count_r;
  logic [IW-1:0]   index_r;
  logic            circ_r;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            issue_s;
  logic            arm_s;
  logic            last_s;
  logic            flush_s;
  logic            unused_dout_s;

  function automatic logic [31:0] sext(input logic [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

  function automatic logic [31:0] word_addr(input logic [IW-1:0] idx);
    return BASE_ADDR + {{(30-IW){1'b0}}, idx, 2'b00};
  endfunction

  assign BRAM_clk      = clk;
  assign unused_dout_s = ^BRAM_dout;

  assign fifo_full_s  = (count_r == FCW'(FIFO_DEPTH));
  assign fifo_empty_s = (count_r == {FCW{1'b0}});
  assign sample_ready = (state_r == ST_CAPTURE) && !fifo_full_s;
  assign push_s       = sample_valid && sample_ready;
  assign issue_s      = !fifo_empty_s && bram_grant &&
                        ((state_r == ST_CAPTURE) || (state_r == ST_DRAIN));
  assign arm_s        = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_s       = issue_s && (index_r == IW'(NUM_WORDS - 1));
  // A one-shot capture throws away whatever is still queued after its final word.
  assign flush_s      = arm_s || (last_s && !circ_r);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the final one-shot write wins over a coincident stop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arm) state_nxt_s = ST_CAPTURE;
        else     state_nxt_s = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (last_s && !circ_r) state_nxt_s = ST_DONE;
        else if (stop)         state_nxt_s = ST_DRAIN;
        else                   state_nxt_s = ST_CAPTURE;
      end
      ST_DRAIN: begin
        if (last_s && !circ_r) state_nxt_s = ST_DONE;
        else if (fifo_empty_s) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (arm) state_nxt_s = ST_CAPTURE;
        else     state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because count_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= sample_in;
  end

  // FIFO pointers, BRAM write port, index and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {FCW{1'b0}};
      index_r       <= {IW{1'b0}};
      circ_r        <= 1'b0;
      BRAM_addr     <= 32'h0000_0000;
      BRAM_din      <= 32'h0000_0000;
      BRAM_en       <= 1'b0;
      BRAM_we       <= 4'h0;
      BRAM_rst      <= 1'b1;
      done          <= 1'b0;
      wrapped       <= 1'b0;
      overflow      <= 1'b0;
      words_written <= {CW{1'b0}};
    end else begin
      BRAM_rst <= 1'b0;
      if (arm_s) circ_r <= circular;

      if (issue_s) begin
        BRAM_en   <= 1'b1;
        BRAM_we   <= 4'hF;
        BRAM_addr <= word_addr(index_r);
        BRAM_din  <= sext(mem_r[rd_ptr_r]);
      end else begin
        BRAM_en <= 1'b0;
        BRAM_we <= 4'h0;
      end

      if (arm_s || last_s) index_r <= {IW{1'b0}};
      else if (issue_s)    index_r <= index_r + IW'(1);

      if (arm_s)                    wrapped <= 1'b0;
      else if (last_s && circ_r)    wrapped <= 1'b1;

      if (arm_s) overflow <= 1'b0;
      else if ((state_r == ST_CAPTURE) && sample_valid && !sample_ready) overflow <= 1'b1;

      done <= (state_r == ST_DONE) && !arm_s;

      if (arm_s) words_written <= {CW{1'b0}};
      else if (issue_s && (words_written != CW'(NUM_WORDS)))
        words_written <= words_written + CW'(1);

      if (flush_s) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        count_r  <= {FCW{1'b0}};
      end else begin
        if (push_s)  wr_ptr_r <= wr_ptr_r + PW'(1);
        if (issue_s) rd_ptr_r <= rd_ptr_r + PW'(1);
        case ({push_s, issue_s})
          2'b10:   count_r <= count_r + FCW'(1);
          2'b01:   count_r <= count_r - FCW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_bram_capture.sv
// tb_i2s_bram_capture: directed checks of one-shot, circular, backpressure, stop/drain
// and asynchronous reset behaviour of i2s_bram_capture.
module tb_i2s_bram_capture;

  localparam int          NW   = 8;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'h0000_0040;

  logic        clk;
  logic        rst;
  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic [31:0] BRAM_dout;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;
  logic        bram_grant;
  logic        arm;
  logic        stop;
  logic        circular;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        done;
  logic        wrapped;
  logic        overflow;
  logic [3:0]  words_written;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [3:0]  wwe[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  i2s_bram_capture #(.NUM_WORDS(NW), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .BRAM_addr(BRAM_addr), .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din),
    .BRAM_dout(BRAM_dout), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_we(BRAM_we),
    .bram_grant(bram_grant), .arm(arm), .stop(stop), .circular(circular),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .done(done), .wrapped(wrapped), .overflow(overflow), .words_written(words_written)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every BRAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (BRAM_en) begin
      wa.push_back(BRAM_addr);
      wd.push_back(BRAM_din);
      wwe.push_back(BRAM_we);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_capture(input logic circ);
    circular = circ;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push(input logic [15:0] s);
    int n = 0;
    sample_in = s;
    sample_valid = 1'b1;
    while (!sample_ready && n < 50) begin
      tick();
      n++;
    end
    check_value("push_ready", {31'h0, sample_ready}, 32'h1);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check_value(tag, {31'h0, done}, 32'h1);
  endtask

  task automatic expect_write(input int idx, input logic [15:0] s);
    exp_a.push_back(BASE + 32'(idx) * 32'd4);
    exp_d.push_back({{16{s[15]}}, s});
  endtask

  task automatic compare_writes(input string tag);
    check_value({tag, "_count"}, 32'(wa.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wa.size(); i++) begin
      check_value($sformatf("%s_addr%0d", tag, i), wa[i], exp_a[i]);
      check_value($sformatf("%s_data%0d", tag, i), wd[i], exp_d[i]);
      check_value($sformatf("%s_we%0d", tag, i), {28'h0, wwe[i]}, 32'hF);
    end
    wa.delete(); wd.delete(); wwe.delete(); exp_a.delete(); exp_d.delete();
  endtask

  initial begin
    rst = 1'b0; bram_grant = 1'b0; arm = 1'b0; stop = 1'b0; circular = 1'b0;
    sample_in = 16'h0000; sample_valid = 1'b0; BRAM_dout = 32'h0000_0000;

    // Reset values.
    repeat (2) tick();
    check_value("rst_addr", BRAM_addr, 32'h0);
    check_value("rst_din", BRAM_din, 32'h0);
    check_value("rst_en", {31'h0, BRAM_en}, 32'h0);
    check_value("rst_we", {28'h0, BRAM_we}, 32'h0);
    check_value("rst_bram_rst", {31'h0, BRAM_rst}, 32'h1);
    check_value("rst_done", {31'h0, done}, 32'h0);
    check_value("rst_wrapped", {31'h0, wrapped}, 32'h0);
    check_value("rst_overflow", {31'h0, overflow}, 32'h0);
    check_value("rst_words", {28'h0, words_written}, 32'h0);
    check_value("rst_ready", {31'h0, sample_ready}, 32'h0);
    rst = 1'b1;
    tick();
    check_value("bram_rst_release", {31'h0, BRAM_rst}, 32'h0);

    // One-shot, 8 back-to-back samples, grant high.
    bram_grant = 1'b1;
    arm_capture(1'b0);
    check_value("arm_ready", {31'h0, sample_ready}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      push(16'(i));
      expect_write(i - 1, 16'(i));
    end
    check_value("os_done_early", {31'h0, done}, 32'h0);
    tick();
    check_value("os_last_en", {31'h0, BRAM_en}, 32'h1);
    check_value("os_done_at_last", {31'h0, done}, 32'h0);
    tick();
    check_value("os_done", {31'h0, done}, 32'h1);
    check_value("os_en_off", {31'h0, BRAM_en}, 32'h0);
    check_value("os_words", {28'h0, words_written}, 32'd8);
    check_value("os_overflow", {31'h0, overflow}, 32'h0);
    compare_writes("oneshot");

    // Sign extension.
    arm_capture(1'b0);
    check_value("sx_done_clr", {31'h0, done}, 32'h0);
    push(16'h8000); expect_write(0, 16'h8000);
    push(16'h7FFF); expect_write(1, 16'h7FFF);
    stop_pulse();
    wait_done("sx_done");
    check_value("sx_words", {28'h0, words_written}, 32'd2);
    compare_writes("sext");

    // Backpressure with grant low.
    bram_grant = 1'b0;
    arm_capture(1'b0);
    for (int i = 0; i < 4; i++) begin
      push(16'h0A01 + 16'(i));
      expect_write(i, 16'h0A01 + 16'(i));
    end
    check_value("bp_ready_low", {31'h0, sample_ready}, 32'h0);
    check_value("bp_no_ovf_yet", {31'h0, overflow}, 32'h0);
    sample_in = 16'h0A05; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check_value("bp_overflow", {31'h0, overflow}, 32'h1);
    check_value("bp_no_write", 32'(wa.size()), 32'h0);
    bram_grant = 1'b1;
    repeat (5) tick();
    check_value("bp_words", {28'h0, words_written}, 32'd4);
    compare_writes("bp");
    stop_pulse();
    wait_done("bp_done");

    // Circular: 10 samples wrap past the 8-word buffer.
    arm_capture(1'b1);
    check_value("circ_ovf_clr", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      push(16'hC000 + 16'(i));
      expect_write(i % NW, 16'hC000 + 16'(i));
    end
    repeat (3) tick();
    check_value("circ_wrapped", {31'h0, wrapped}, 32'h1);
    check_value("circ_words", {28'h0, words_written}, 32'd8);
    check_value("circ_not_done", {31'h0, done}, 32'h0);
    compare_writes("circ");
    stop_pulse();
    wait_done("circ_done");

    // Stop with three samples queued behind a low grant.
    bram_grant = 1'b0;
    arm_capture(1'b0);
    check_value("st_wrapped_clr", {31'h0, wrapped}, 32'h0);
    check_value("st_words_clr", {28'h0, words_written}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      push(16'h0500 + 16'(i));
      expect_write(i, 16'h0500 + 16'(i));
    end
    stop_pulse();
    check_value("st_ready_drop", {31'h0, sample_ready}, 32'h0);
    sample_in = 16'h0599; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check_value("st_no_ovf_drain", {31'h0, overflow}, 32'h0);
    check_value("st_not_done", {31'h0, done}, 32'h0);
    bram_grant = 1'b1;
    wait_done("st_done");
    compare_writes("stop");
    arm_capture(1'b0);
    check_value("rearm_done_clr", {31'h0, done}, 32'h0);
    check_value("rearm_words_clr", {28'h0, words_written}, 32'h0);

    // Asynchronous reset in the middle of a write.
    push(16'h1111);
    push(16'h2222);
    check_value("ar_mid_en", {31'h0, BRAM_en}, 32'h1);
    #1 rst = 1'b0;
    #1;
    check_value("ar_en", {31'h0, BRAM_en}, 32'h0);
    check_value("ar_we", {28'h0, BRAM_we}, 32'h0);
    check_value("ar_addr", BRAM_addr, 32'h0);
    check_value("ar_din", BRAM_din, 32'h0);
    check_value("ar_bram_rst", {31'h0, BRAM_rst}, 32'h1);
    check_value("ar_words", {28'h0, words_written}, 32'h0);
    check_value("ar_ready", {31'h0, sample_ready}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    wa.delete(); wd.delete(); wwe.delete(); exp_a.delete(); exp_d.delete();
    arm_capture(1'b0);
    push(16'h4444); expect_write(0, 16'h4444);
    push(16'h5555); expect_write(1, 16'h5555);
    repeat (2) tick();
    check_value("ar_rearm_words", {28'h0, words_written}, 32'd2);
    compare_writes("rearm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
